// File: rtl/cpu_pkg.sv
// Shared types and defaults for the memory-access stage.
// Build option MEM_TIMEOUT_EN enables the access timeout.
package cpu_pkg;

  localparam int DW_DEF  = 32;
  localparam int RDW_DEF = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts ACCESS cycles without ack; pulses tc on the LIMIT-th one.
// Instantiated by mem_access_stage only under MEM_TIMEOUT_EN.
module mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // tc fires on the cycle whose increment would reach LIMIT
  assign tc = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/ack data port and registers MEM/WB.
// Build option MEM_TIMEOUT_EN aborts accesses after TIMEOUT_CYCLES.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int RDW            = RDW_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [DW-1:0]  alu_res,
  input  logic [DW-1:0]  store_data,
  input  logic [RDW-1:0] wr_dest,
  input  logic           wmem,
  input  logic           rmem,
  input  logic           wreg,
  input  logic           jmp,
  output logic           stall_o,
  output logic           mem_req,
  output logic           mem_we,
  output logic [DW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic           mem_ack,
  input  logic [DW-1:0]  mem_rdata,
  output logic           wb_valid,
  output logic [DW-1:0]  wb_data,
  output logic [RDW-1:0] wb_dest,
  output logic           wb_wreg,
  output logic           wb_jmp,
  output logic           mem_err
);

  mem_state_t     state_q, state_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [DW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [RDW-1:0] dest_q, dest_d;
  logic           wreg_q, wreg_d;
  logic           jmp_q, jmp_d;
  logic           load_q, load_d;
  logic           wbv_q, wbv_d;
  logic [DW-1:0]  wbd_q, wbd_d;
  logic [RDW-1:0] wbr_q, wbr_d;
  logic           wbw_q, wbw_d;
  logic           wbj_q, wbj_d;
  logic           err_q, err_d;
  logic           is_mem;
  logic           timeout;
  logic           in_acc;

  assign is_mem = rmem | wmem;
  assign in_acc = (state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_to (
    .clk(clk),
    .rst(rst),
    .clr(!in_acc),
    .en (in_acc && !mem_ack),
    .tc (timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  assign stall_o = in_valid && is_mem &&
                   !(in_acc && (mem_ack || timeout));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dest_d  = dest_q;
    wreg_d  = wreg_q;
    jmp_d   = jmp_q;
    load_d  = load_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    wbr_d   = wbr_q;
    wbw_d   = wbw_q;
    wbj_d   = wbj_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !is_mem) begin
          wbv_d = 1'b1;
          wbd_d = alu_res;
          wbr_d = wr_dest;
          wbw_d = wreg;
          wbj_d = jmp;
        end else if (in_valid) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          we_d    = wmem;
          addr_d  = alu_res;
          wdata_d = store_data;
          dest_d  = wr_dest;
          wreg_d  = wreg;
          jmp_d   = jmp;
          load_d  = !wmem;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbd_d   = load_q ? mem_rdata : addr_q;
          wbr_d   = dest_q;
          wbw_d   = wreg_q;
          wbj_d   = jmp_q;
        end else if (timeout) begin
          // aborted access retires without a register write
          state_d = IDLE;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wbd_d   = addr_q;
          wbr_d   = dest_q;
          wbw_d   = 1'b0;
          wbj_d   = jmp_q;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dest_q  <= '0;
      wreg_q  <= 1'b0;
      jmp_q   <= 1'b0;
      load_q  <= 1'b0;
      wbv_q   <= 1'b0;
      wbd_q   <= '0;
      wbr_q   <= '0;
      wbw_q   <= 1'b0;
      wbj_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dest_q  <= dest_d;
      wreg_q  <= wreg_d;
      jmp_q   <= jmp_d;
      load_q  <= load_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      wbr_q   <= wbr_d;
      wbw_q   <= wbw_d;
      wbj_q   <= wbj_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wbv_q;
  assign wb_data   = wbd_q;
  assign wb_dest   = wbr_q;
  assign wb_wreg   = wbw_q;
  assign wb_jmp    = wbj_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, directed corners and
// random program checked against an in-order architectural model.
module tb_mem_access_stage;

  localparam int DW  = 32;
  localparam int RDW = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [DW-1:0]  alu_res;
  logic [DW-1:0]  store_data;
  logic [RDW-1:0] wr_dest;
  logic           wmem, rmem, wreg, jmp;
  logic           stall_o;
  logic           mem_req, mem_we;
  logic [DW-1:0]  mem_addr, mem_wdata;
  logic           mem_ack;
  logic [DW-1:0]  mem_rdata;
  logic           wb_valid;
  logic [DW-1:0]  wb_data;
  logic [RDW-1:0] wb_dest;
  logic           wb_wreg, wb_jmp;
  logic           mem_err;

  mem_access_stage #(
    .DW(DW),
    .RDW(RDW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .alu_res(alu_res),
    .store_data(store_data),
    .wr_dest(wr_dest),
    .wmem(wmem),
    .rmem(rmem),
    .wreg(wreg),
    .jmp(jmp),
    .stall_o(stall_o),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .wb_valid(wb_valid),
    .wb_data(wb_data),
    .wb_dest(wb_dest),
    .wb_wreg(wb_wreg),
    .wb_jmp(wb_jmp),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v, rm, wm, wr, jp;
    logic [31:0] alu, sd;
    logic [3:0] dst;
  } ins_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0] dst;
    logic wr, jp;
  } ret_t;

  typedef struct {
    logic [31:0] a;
    logic we;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    ins_t i;
    int lat;
    logic [31:0] rdata;
    logic [31:0] x_data;
    int x_wblat, x_reqc, x_stallc;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  int n_ret;

  ins_t prog[$];
  int   lats[$];
  ret_t xret[$];
  req_t xreq[$];
  bit   tr_req[$], tr_wb[$], tr_st[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail1(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected", nm);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return init_val(a);
  endfunction

  function automatic ins_t mk(input logic rm, wm, wr, jp,
                              input logic [31:0] alu, sd,
                              input logic [3:0] dst);
    ins_t t;
    t.v = 1'b1; t.rm = rm; t.wm = wm; t.wr = wr; t.jp = jp;
    t.alu = alu; t.sd = sd; t.dst = dst;
    return t;
  endfunction

  // architectural effect of one instruction, in program order
  task automatic model(input ins_t t);
    ret_t r;
    req_t q;
    r.dst = t.dst; r.wr = t.wr; r.jp = t.jp;
    if (t.rm || t.wm) begin
      q.a = t.alu; q.we = t.wm; q.wd = t.sd;
      xreq.push_back(q);
      if (t.wm) begin
        ref_mem[t.alu] = t.sd;
        r.d = t.alu;
      end else begin
        r.d = ref_rd(t.alu);
      end
    end else begin
      r.d = t.alu;
    end
    xret.push_back(r);
  endtask

  task automatic drive(input ins_t t);
    in_valid = t.v; rmem = t.rm; wmem = t.wm;
    wreg = t.wr; jmp = t.jp; alu_res = t.alu;
    store_data = t.sd; wr_dest = t.dst;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0; rmem = 1'b0; wmem = 1'b0;
    wreg = 1'b0; jmp = 1'b0;
  endtask

  task automatic run_prog(input int budget);
    ins_t cur;
    bit have, act, done;
    int w, lat;
    req_t er;
    ret_t rr;
    have = 0; act = 0; done = 0; w = 0; lat = 0;
    er = '{a: 0, we: 0, wd: 0};
    tr_req.delete(); tr_wb.delete(); tr_st.delete();
    n_ret = 0;
    for (int c = 0; c < budget && !done; c++) begin
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!have && prog.size() > 0) begin
        cur = prog.pop_front();
        have = 1;
        if (cur.v) model(cur);
      end
      if (have) drive(cur);
      else drive_idle();
      if (mem_req) begin
        if (!act) begin
          act = 1; w = 0;
          lat = (lats.size() > 0) ? lats.pop_front() : 0;
          if (xreq.size() == 0) begin
            fail1("unexpected_req");
          end else begin
            er = xreq.pop_front();
            chk("req_addr", mem_addr, er.a);
            chk("req_we", {31'b0, mem_we}, {31'b0, er.we});
            if (er.we) chk("req_wdata", mem_wdata, er.wd);
          end
        end else begin
          chk("req_hold_addr", mem_addr, er.a);
        end
        if (w == lat) begin
          mem_ack = 1'b1;
          mem_rdata = dev_rd(mem_addr);
          if (mem_we) dev_mem[mem_addr] = mem_wdata;
          act = 0;
        end
        w++;
      end
      tr_req.push_back(mem_req);
      @(negedge clk);
      tr_wb.push_back(wb_valid);
      tr_st.push_back(stall_o);
      if (wb_valid) begin
        if (xret.size() == 0) begin
          fail1("unexpected_wb");
        end else begin
          rr = xret.pop_front();
          chk("wb_data", wb_data, rr.d);
          chk("wb_dest", {28'b0, wb_dest}, {28'b0, rr.dst});
          chk("wb_wreg", {31'b0, wb_wreg}, {31'b0, rr.wr});
          chk("wb_jmp", {31'b0, wb_jmp}, {31'b0, rr.jp});
          n_ret++;
        end
      end
      if (have && cur.v && !(cur.rm || cur.wm))
        chk("nonmem_stall", {31'b0, stall_o}, 32'd0);
      if (have && (!cur.v || !stall_o)) have = 0;
      @(posedge clk);
      #1;
      if (!have && prog.size() == 0 &&
          xret.size() == 0 && xreq.size() == 0)
        done = 1;
    end
    mem_ack = 1'b0;
    drive_idle();
    if (!done) fail1("drain_budget");
    prog.delete(); lats.delete(); xret.delete(); xreq.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wbv"}, {31'b0, wb_valid}, 32'd0);
    chk({tag, "_wbd"}, wb_data, 32'd0);
    chk({tag, "_wbr"}, {28'b0, wb_dest}, 32'd0);
    chk({tag, "_wbw"}, {31'b0, wb_wreg}, 32'd0);
    chk({tag, "_wbj"}, {31'b0, wb_jmp}, 32'd0);
    chk({tag, "_err"}, {31'b0, mem_err}, 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int first_wb, reqc, stc, r1, f1, r2, nv;
    int sel;
    ins_t t;

    tbl[0] = '{mk(0,0,1,0,32'h1234,32'h0,4'd5), 0, 32'h0,
               32'h1234, 1, 0, 0};
    tbl[1] = '{mk(1,0,1,0,32'h40,32'h0,4'd3), 2, 32'hDEADBEEF,
               32'hDEADBEEF, 4, 3, 3};
    tbl[2] = '{mk(0,1,0,0,32'h80,32'h55,4'd0), 0, 32'h0,
               32'h80, 2, 1, 1};
    tbl[3] = '{mk(1,1,0,0,32'h100,32'h77,4'd2), 1, 32'hFFFF0000,
               32'h100, 3, 2, 2};
    tbl[4] = '{mk(0,0,0,1,32'hCAFE0000,32'h0,4'd15), 0, 32'h0,
               32'hCAFE0000, 1, 0, 0};
    tbl[5] = '{mk(1,0,1,1,32'hFFFFFFFC,32'h0,4'd1), 0, 32'h0BAD_F00D,
               32'h0BAD_F00D, 2, 1, 1};

    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    alu_res = '0; store_data = '0; wr_dest = '0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst0");
    chk("rst0_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      dev_mem[tbl[i].i.alu] = tbl[i].rdata;
      ref_mem[tbl[i].i.alu] = tbl[i].rdata;
      prog.push_back(tbl[i].i);
      lats.push_back(tbl[i].lat);
      run_prog(50);
      first_wb = -1; reqc = 0; stc = 0;
      for (int k = 0; k < tr_wb.size(); k++) begin
        if (tr_wb[k] && first_wb < 0) first_wb = k;
        if (tr_req[k]) reqc++;
        if (tr_st[k]) stc++;
      end
      chk($sformatf("v%0d_wblat", i), first_wb, tbl[i].x_wblat);
      chk($sformatf("v%0d_reqc", i), reqc, tbl[i].x_reqc);
      chk($sformatf("v%0d_stallc", i), stc, tbl[i].x_stallc);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'b0, wb_valid}, 32'd0);
      chk($sformatf("v%0d_hold", i), wb_data, tbl[i].x_data);
      chk($sformatf("v%0d_reqlow", i), {31'b0, mem_req}, 32'd0);
      @(posedge clk);
      #1;
    end

    prog.push_back(mk(1,0,1,0,32'h200,32'h0,4'd6));
    prog.push_back(mk(0,1,0,0,32'h300,32'h99,4'd0));
    lats.push_back(1);
    lats.push_back(0);
    run_prog(50);
    r1 = -1; f1 = -1; r2 = -1;
    for (int k = 0; k < tr_req.size(); k++) begin
      if (r1 < 0 && tr_req[k]) r1 = k;
      else if (r1 >= 0 && f1 < 0 && !tr_req[k]) f1 = k;
      else if (f1 >= 0 && r2 < 0 && tr_req[k]) r2 = k;
    end
    chk("b2b_rise1", r1, 1);
    chk("b2b_gap", r2 - f1, 1);
    chk("b2b_rets", n_ret, 2);

    nv = 0;
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 3);
      t = mk(sel == 1 || sel == 3, sel == 2 || sel == 3,
             1'($urandom), 1'($urandom),
             32'h1000 + 32'($urandom_range(0, 7)) * 4,
             $urandom, 4'($urandom));
      if (sel == 0) t.alu = $urandom;
      if ($urandom_range(0, 6) == 0) t.v = 1'b0;
      else nv++;
      prog.push_back(t);
      if (t.rm || t.wm) lats.push_back($urandom_range(0, 2));
    end
    // lats for bubbles are never consumed; trim by consuming in order
    run_prog(5000);
    chk("rand_rets", n_ret, nv);
    chk("rand_err", {31'b0, mem_err}, 32'd0);

    drive(mk(1,0,1,1,32'h500,32'h0,4'd9));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_acc1_req", {31'b0, mem_req}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk_reset_outs("rstmid");
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_wbv", {31'b0, wb_valid}, 32'd0);
    chk("late_ack_req", {31'b0, mem_req}, 32'd0);
    chk("late_ack_wbd", wb_data, 32'd0);
    @(posedge clk);
    #1;

`ifdef MEM_TIMEOUT_EN
    begin
      int wbc;
      bit drop;
      reqc = 0; wbc = -1; drop = 0;
      drive(mk(1,0,1,0,32'h600,32'h0,4'd7));
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (mem_req) reqc++;
        if (c == 3)
          chk("to_stall_hi", {31'b0, stall_o}, 32'd1);
        if (c == 4)
          chk("to_stall_drop", {31'b0, stall_o}, 32'd0);
        if (in_valid && !stall_o) drop = 1;
        if (wb_valid && wbc < 0) begin
          wbc = c;
          chk("to_wreg", {31'b0, wb_wreg}, 32'd0);
          chk("to_err", {31'b0, mem_err}, 32'd1);
          chk("to_req_low", {31'b0, mem_req}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (drop) drive_idle();
      end
      chk("to_reqc", reqc, 4);
      chk("to_wbcyc", wbc, 5);
      chk("to_sticky", {31'b0, mem_err}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("to_err_clr", {31'b0, mem_err}, 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
